// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_EARLY_EXIT_EN: finish in one step when dividend < divisor.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Zero-divisor and early-exit jobs spend a single RUN cycle and then load a fixed result.
    typedef enum logic [1:0] {OP_DIVIDE, OP_ZERO, OP_SMALL} op_t;

    state_t         state, state_next;
    op_t            op, op_next;
    logic [2*N-1:0] q_reg, q_next;
    // Partial remainder stays below the divisor, so N bits hold it; the trial value adds the extra bit.
    logic [N-1:0]   r_reg, r_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [N-1:0]   dvsr, dvsr_next;
    logic [2*N-1:0] quotient_next;
    logic [N-1:0]   remainder_next;
    logic           div_by_zero_next;

    logic [N:0]     trial;
    logic           bit_q;
    logic [N-1:0]   r_step;

    assign trial  = {r_reg, q_reg[2*N-1]};
    assign bit_q  = (trial >= {1'b0, dvsr});
    assign r_step = bit_q ? N'(trial - {1'b0, dvsr}) : trial[N-1:0];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_DIVIDE;
            q_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            op          <= op_next;
            q_reg       <= q_next;
            r_reg       <= r_next;
            cnt         <= cnt_next;
            dvsr        <= dvsr_next;
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= div_by_zero_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next       = state;
        op_next          = op;
        q_next           = q_reg;
        r_next           = r_reg;
        cnt_next         = cnt;
        dvsr_next        = dvsr;
        quotient_next    = quotient;
        remainder_next   = remainder;
        div_by_zero_next = div_by_zero;

        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    state_next = RUN;
                    dvsr_next  = divisor;
                    q_next     = dividend;
                    r_next     = '0;
                    op_next    = OP_DIVIDE;
                    cnt_next   = '0;
                    if (divisor == '0) begin
                        op_next  = OP_ZERO;
                        cnt_next = LAST;
                    end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                    else if (dividend < {{N{1'b0}}, divisor}) begin
                        op_next  = OP_SMALL;
                        cnt_next = LAST;
                    end
`endif
                end
            end

            RUN: begin
                if (op == OP_DIVIDE) begin
                    q_next   = {q_reg[2*N-2:0], bit_q};
                    r_next   = r_step;
                    cnt_next = cnt + CW'(1);
                end
                if (cnt == LAST) begin
                    state_next = DONE;
                    case (op)
                        OP_ZERO: begin
                            quotient_next    = '1;
                            remainder_next   = q_reg[N-1:0];
                            div_by_zero_next = 1'b1;
                        end
                        OP_SMALL: begin
                            quotient_next    = '0;
                            remainder_next   = q_reg[N-1:0];
                            div_by_zero_next = 1'b0;
                        end
                        default: begin
                            quotient_next    = {q_reg[2*N-2:0], bit_q};
                            remainder_next   = r_step;
                            div_by_zero_next = 1'b0;
                        end
                    endcase
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
